// File: rtl/debug_snapshot_ctrl_if.sv
// rtl/debug_snapshot_ctrl_if.sv - frame control, debug source read port and display read port bundle
interface debug_snapshot_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              frame_start;
  logic              freeze;
  logic              src_req;
  logic [6:0]        src_addr;
  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic [6:0]        disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              busy;
  logic [15:0]       snap_count;
  logic              overrun;

  modport master (
    input  frame_start, freeze, src_data, src_valid, disp_addr,
    output src_req, src_addr, disp_data, busy, snap_count, overrun
  );

  modport slave (
    output frame_start, freeze, src_data, src_valid, disp_addr,
    input  src_req, src_addr, disp_data, busy, snap_count, overrun
  );
endinterface

// File: rtl/debug_snapshot_ctrl.sv
// rtl/debug_snapshot_ctrl.sv - frame-coherent double-buffered capture of debug entries for the text display
module debug_snapshot_ctrl #(
  parameter int                ENTRIES      = 120,
  parameter int                DATA_W       = 32,
  parameter int                TIMEOUT      = 16,
  parameter logic [DATA_W-1:0] TIMEOUT_WORD = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  reset,
  debug_snapshot_ctrl_if.master bus
);

  localparam int TW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]        r_state;
  logic [6:0]        r_idx;
  logic [TW-1:0]     r_timer;
  logic              r_front;
  logic              r_pending;
  logic              r_front_valid;
  logic              r_overrun;
  logic [15:0]       r_snap_count;
  logic [DATA_W-1:0] r_disp_data;

  // Bank r_front feeds the display; bank ~r_front is the capture target.
  logic [DATA_W-1:0] r_mem [0:1][0:ENTRIES-1];

  logic              w_last;
  logic              w_timeout;
  logic              w_write;
  logic [DATA_W-1:0] w_wdata;
  logic              w_disp_hit;

  always_comb begin
    w_last     = (r_idx == 7'(ENTRIES - 1));
    w_timeout  = (r_timer == TW'(TIMEOUT - 1));
    w_write    = (r_state == S_WAIT) && (bus.src_valid || w_timeout);
    w_wdata    = bus.src_valid ? bus.src_data : TIMEOUT_WORD;
    w_disp_hit = r_front_valid && ({1'b0, bus.disp_addr} < 8'(ENTRIES));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_timer       <= '0;
      r_front       <= 1'b0;
      r_pending     <= 1'b0;
      r_front_valid <= 1'b0;
      r_overrun     <= 1'b0;
      r_snap_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.frame_start) begin
            // Swap first so a new capture lands in the bank just retired from display.
            if (r_pending) begin
              r_front       <= ~r_front;
              r_pending     <= 1'b0;
              r_front_valid <= 1'b1;
            end
            if (!bus.freeze) begin
              r_idx   <= '0;
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_write) begin
            if (w_last) begin
              r_pending    <= 1'b1;
              r_snap_count <= r_snap_count + 16'd1;
              r_state      <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 7'd1;
              r_state <= S_REQ;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (bus.frame_start && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_write && !reset) begin
      r_mem[~r_front][r_idx] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_disp_data <= '0;
    end else if (w_disp_hit) begin
      r_disp_data <= r_mem[r_front][bus.disp_addr];
    end else begin
      r_disp_data <= '0;
    end
  end

  assign bus.src_req    = (r_state == S_REQ);
  assign bus.src_addr   = r_idx;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.disp_data  = r_disp_data;
  assign bus.snap_count = r_snap_count;
  assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_debug_snapshot_ctrl.sv
// tb/tb_debug_snapshot_ctrl.sv - randomized scoreboard bench for debug_snapshot_ctrl
module tb_debug_snapshot_ctrl;

  typedef struct {
    logic [31:0] exp;
    int          due;
    int          a;
  } dchk_t;

  logic clk;
  logic reset;
  int   cyc = 0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  debug_snapshot_ctrl_if #(.DATA_W(32)) bus ();

  debug_snapshot_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Source behaviour per capture: delay k in 1..16 answers on the k-th WAIT cycle, 0 never answers.
  int          cfg_delay [120];
  logic [31:0] cfg_base;

  // Reference model: whole-frame images rather than banks.
  logic [31:0] m_front [120];
  logic [31:0] m_next  [120];
  logic [31:0] m_cap   [120];
  bit          m_front_valid, m_pending, m_busy, m_ovr;
  int          m_snap;
  int          m_busy_len;

  int    addr_q [$];
  dchk_t disp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_status();
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("snap_count", 32'(bus.snap_count), 32'(m_snap[15:0]));
    chk("overrun", 32'(bus.overrun), 32'(m_ovr));
  endtask

  task automatic model_reset();
    m_front_valid = 0;
    m_pending     = 0;
    m_busy        = 0;
    m_ovr         = 0;
    m_snap        = 0;
  endtask

  task automatic set_cfg(input logic [31:0] base, input bit zero_wait, input bit drop5);
    cfg_base = base;
    for (int a = 0; a < 120; a++) begin
      if (zero_wait) cfg_delay[a] = 1;
      else if ($urandom_range(0, 9) == 0) cfg_delay[a] = 0;
      else cfg_delay[a] = $urandom_range(1, 16);
    end
    if (drop5) cfg_delay[5] = 0;
  endtask

  task automatic issue_rd(input int a);
    dchk_t d;
    bus.disp_addr = 7'(a);
    d.exp = (m_front_valid && a < 120) ? m_front[a] : 32'h0;
    d.due = cyc + 1;
    d.a   = a;
    disp_q.push_back(d);
  endtask

  task automatic read_burst(input int n);
    for (int i = 0; i < n; i++) begin
      issue_rd($urandom_range(0, 127));
      @(negedge clk);
    end
  endtask

  task automatic frame_pulse(input bit frz);
    bus.freeze      = frz;
    bus.frame_start = 1'b1;
    if (m_busy) begin
      m_ovr = 1;
    end else begin
      if (m_pending) begin
        m_front       = m_cap;
        m_pending     = 0;
        m_front_valid = 1;
      end
      if (!frz) begin
        m_busy     = 1;
        m_busy_len = 0;
        for (int a = 0; a < 120; a++) begin
          m_next[a]   = (cfg_delay[a] == 0) ? 32'hDEAD_BEEF : cfg_base + 32'(a);
          m_busy_len += (cfg_delay[a] == 0) ? 17 : cfg_delay[a] + 1;
          addr_q.push_back(a);
        end
      end
    end
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  task automatic wait_capture(input int inject_at);
    int n;
    n = 0;
    while (bus.busy && n < 3000) begin
      n++;
      bus.frame_start = (n == inject_at);
      if (n == inject_at) m_ovr = 1;
      issue_rd($urandom_range(0, 127));
      @(negedge clk);
    end
    bus.frame_start = 1'b0;
    chk("busy_cycles", 32'(n), 32'(m_busy_len));
    m_busy    = 0;
    m_pending = 1;
    m_snap++;
    m_cap     = m_next;
  endtask

  initial begin : responder
    int a, k;
    bus.src_valid = 1'b0;
    bus.src_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.src_req) begin
        a = int'(bus.src_addr);
        k = (a < 120) ? cfg_delay[a] : 0;
        // Noise in the REQ cycle must be ignored.
        bus.src_valid = ($urandom_range(0, 1) == 1);
        bus.src_data  = $urandom;
        for (int j = 1; j <= 16; j++) begin
          @(negedge clk);
          bus.src_valid = (j == k);
          bus.src_data  = (j == k) ? cfg_base + 32'(a) : $urandom;
          if (j == k) break;
        end
      end else begin
        bus.src_valid = ($urandom_range(0, 7) == 0);
        bus.src_data  = $urandom;
      end
    end
  end

  initial begin : monitor
    dchk_t d;
    int    e;
    forever begin
      @(negedge clk);
      if (bus.src_req) begin
        if (addr_q.size() == 0) begin
          chk("src_req_unexpected", 32'(bus.src_addr), 32'hFFFF_FFFF);
        end else begin
          e = addr_q.pop_front();
          chk("src_addr", 32'(bus.src_addr), 32'(e));
        end
      end
      while (disp_q.size() > 0 && disp_q[0].due <= cyc) begin
        d = disp_q.pop_front();
        chk($sformatf("disp_data[%0d]", d.a), bus.disp_data, d.exp);
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    reset           = 1'b1;
    bus.frame_start = 1'b0;
    bus.freeze      = 1'b0;
    bus.disp_addr   = '0;
    model_reset();
    set_cfg(32'h1000_0000, 1'b1, 1'b0);
    repeat (3) @(negedge clk);

    chk("rst_src_req", 32'(bus.src_req), 32'h0);
    chk("rst_src_addr", 32'(bus.src_addr), 32'h0);
    chk("rst_disp_data", bus.disp_data, 32'h0);
    chk_status();
    reset = 1'b0;
    read_burst(8);

    // Frame A: zero-wait source.
    frame_pulse(1'b0);
    wait_capture(0);
    chk_status();
    chk("addr_q_drained_a", 32'(addr_q.size()), 32'h0);
    read_burst(16);

    // Frame B with addr 5 timing out; swap A in, overrun 100 cycles into B.
    set_cfg(32'h2000_0000, 1'b0, 1'b1);
    frame_pulse(1'b0);
    wait_capture(100);
    chk_status();
    issue_rd(37);  @(negedge clk);
    issue_rd(120); @(negedge clk);
    issue_rd(127); @(negedge clk);
    issue_rd(0);   @(negedge clk);
    issue_rd(119); @(negedge clk);
    chk("disp37_is_frame_a", m_front[37], 32'h1000_0025);

    // Swap B in without starting a capture.
    frame_pulse(1'b1);
    chk_status();
    issue_rd(5); @(negedge clk);
    issue_rd(6); @(negedge clk);
    read_burst(16);

    // Freeze across two frame starts while the source changes.
    set_cfg(32'h3000_0000, 1'b0, 1'b0);
    frame_pulse(1'b1);
    read_burst(10);
    frame_pulse(1'b1);
    read_burst(10);
    chk_status();

    // Frame C aborted by reset at entry 60.
    set_cfg(32'h4000_0000, 1'b0, 1'b0);
    frame_pulse(1'b0);
    n = 0;
    while (!(bus.src_req && bus.src_addr == 7'd60) && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("reach_entry60", 32'(bus.src_addr), 32'd60);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    addr_q.delete();
    model_reset();
    chk("rst2_src_req", 32'(bus.src_req), 32'h0);
    chk("rst2_src_addr", 32'(bus.src_addr), 32'h0);
    chk("rst2_disp_data", bus.disp_data, 32'h0);
    chk_status();
    read_burst(20);

    // Frame D after reset: invisible until swapped in.
    set_cfg(32'h5000_0000, 1'b0, 1'b0);
    frame_pulse(1'b0);
    wait_capture(0);
    chk_status();
    read_burst(12);
    frame_pulse(1'b1);
    read_burst(24);
    chk_status();

    repeat (3) @(negedge clk);
    chk("addr_q_drained_end", 32'(addr_q.size()), 32'h0);
    chk("disp_q_drained_end", 32'(disp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
